demux_1x4: RTL and testbench
============================

DEMUX_1X4 -- requirements
Module: demux_1x4

Interface
REQ-001 Parameter: WIDTH, 8, data width of the input byte and of each output lane.
REQ-002 Port: clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk_4f.
REQ-004 Port: Entrada  input  WIDTH  time-multiplexed byte stream, one slot per clk_4f cycle.
REQ-005 Port: validEntrada  input  1  qualifies Entrada in the current slot.
REQ-006 Port: Salida0..Salida3  output  WIDTH each  lane 0..3 data, registered.
REQ-007 Port: validSalida0..validSalida3  output  1 each  lane 0..3 valid, registered.
REQ-008 Port: frame_cnt  output  8  count of emitted frames with all four lanes valid.
REQ-009 Port (only with DEMUX_SYNC_EN): sync  input  1  slot-alignment strobe marking slot 0.

Function
REQ-010 A 2-bit slot counter shall increment by 1 every cycle out of reset and wrap 3->0.
REQ-011 Slot k (counter = k) shall map to lane k.
REQ-012 In slot k (k = 0..2) with validEntrada=1, Entrada shall be captured into staging register k and staging valid k set to 1.
REQ-013 In slot k (k = 0..2) with validEntrada=0, staging valid k shall be cleared; staging data k shall retain its old value.
REQ-014 On the edge ending slot 3, all outputs shall update simultaneously: Salida0..2/validSalida0..2 from staging 0..2, Salida3/validSalida3 directly from Entrada/validEntrada.
REQ-015 Outputs shall hold unchanged for the 4 cycles between frame-update edges.
REQ-016 Latency from input edge to output update: lane 0 = 4 cycles, lane 1 = 3, lane 2 = 2, lane 3 = 1.
REQ-017 An output lane whose valid is 0 shall still drive its retained data; consumers ignore it.
REQ-018 frame_cnt shall increment by 1 on a frame-update edge only when all four new valid values are 1.
REQ-019 frame_cnt shall wrap 255->0 without saturation or flag.
REQ-020 Staging-register clearing shall never depend on the output update; staging 0 may be rewritten in the slot after the update.

Reset
REQ-021 While reset=1 at a rising edge: slot counter=0, all staging data and valids=0, Salida0..3=0, validSalida0..3=0, frame_cnt=0.
REQ-022 The first cycle after reset deasserts shall be slot 0.
REQ-023 Reset asserted mid-frame shall discard the partial frame; no output update shall occur for it.

Configuration
REQ-024 Macro DEMUX_SYNC_EN defined: port sync exists; sync=1 at an edge shall treat the current cycle as slot 0 (capture into lane 0, counter set to 1 next), aborting any partial frame without an output update.
REQ-025 Macro DEMUX_SYNC_EN defined: reset has priority over sync.
REQ-026 Macro DEMUX_SYNC_EN undefined: no sync port; the slot counter is free-running from reset only.

Verification
REQ-027 Reset, then 4 valid cycles with Entrada 0xA0,0xA1,0xA2,0xA3 -> after the 4th edge Salida0..3=A0,A1,A2,A3, all validSalida=1, frame_cnt=1.
REQ-028 Same stream with validEntrada=0 in slot 1 -> validSalida1=0, Salida1 retains its previous value, other lanes valid, frame_cnt unchanged.
REQ-029 Continuous valid stream for 256 frames -> frame_cnt wraps to 0; outputs hold steady for 4 cycles between updates.
REQ-030 Reset asserted during slot 2 of a frame -> all outputs 0 next edge; the next full frame of 0x11..0x14 emits correctly with frame_cnt=1.
REQ-031 With DEMUX_SYNC_EN: sync pulsed with 0x55 in counter slot 2 -> 0x55 lands in Salida0 at the next update, 3 cycles later, and no update occurs for the aborted frame.

Source files
------------

// File: rtl/demux_1x4.sv
// 1-to-4 byte demultiplexer: a four-slot time-multiplexed stream is staged and released
// as one registered frame of four lanes. Optional slot alignment input under DEMUX_SYNC_EN.
module demux_1x4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             validEntrada,
`ifdef DEMUX_SYNC_EN
    input  logic             sync,
`endif
    output logic [WIDTH-1:0] Salida0,
    output logic [WIDTH-1:0] Salida1,
    output logic [WIDTH-1:0] Salida2,
    output logic [WIDTH-1:0] Salida3,
    output logic             validSalida0,
    output logic             validSalida1,
    output logic             validSalida2,
    output logic             validSalida3,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned NumStage = 3;

    logic [1:0]       slot_q, slot_d, slot_eff;
    logic             frame_update;
    logic             frame_all_valid;

    logic [WIDTH-1:0] stage_data_q  [NumStage];
    logic [WIDTH-1:0] stage_data_d  [NumStage];
    logic             stage_valid_q [NumStage];
    logic             stage_valid_d [NumStage];

    logic [WIDTH-1:0] salida_q [4];
    logic [3:0]       valid_q;
    logic [7:0]       frame_cnt_q;

    // A sync strobe makes the current cycle slot 0, so a partial frame never reaches slot 3.
    always_comb begin
        slot_eff = slot_q;
`ifdef DEMUX_SYNC_EN
        if (sync) begin
            slot_eff = 2'd0;
        end
`endif
        slot_d       = slot_eff + 2'd1;
        frame_update = (slot_eff == 2'd3);
    end

    always_comb begin
        for (int k = 0; k < NumStage; k++) begin
            stage_data_d[k]  = stage_data_q[k];
            stage_valid_d[k] = stage_valid_q[k];
            if (slot_eff == 2'(k)) begin
                stage_valid_d[k] = validEntrada;
                if (validEntrada) begin
                    stage_data_d[k] = Entrada;
                end
            end
        end
    end

    assign frame_all_valid = frame_update && validEntrada &&
                             stage_valid_q[0] && stage_valid_q[1] && stage_valid_q[2];

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            slot_q <= 2'd0;
            for (int k = 0; k < NumStage; k++) begin
                stage_data_q[k]  <= '0;
                stage_valid_q[k] <= 1'b0;
            end
        end else begin
            slot_q <= slot_d;
            for (int k = 0; k < NumStage; k++) begin
                stage_data_q[k]  <= stage_data_d[k];
                stage_valid_q[k] <= stage_valid_d[k];
            end
        end
    end

    // Lane 3 bypasses staging: it is taken straight from the input on the frame edge.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                salida_q[k] <= '0;
            end
            valid_q     <= 4'b0000;
            frame_cnt_q <= 8'd0;
        end else if (frame_update) begin
            for (int k = 0; k < NumStage; k++) begin
                salida_q[k] <= stage_data_q[k];
            end
            salida_q[3] <= Entrada;
            valid_q     <= {validEntrada, stage_valid_q[2], stage_valid_q[1], stage_valid_q[0]};
            if (frame_all_valid) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign Salida0      = salida_q[0];
    assign Salida1      = salida_q[1];
    assign Salida2      = salida_q[2];
    assign Salida3      = salida_q[3];
    assign validSalida0 = valid_q[0];
    assign validSalida1 = valid_q[1];
    assign validSalida2 = valid_q[2];
    assign validSalida3 = valid_q[3];
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_demux_1x4.sv
// Directed self-checking bench for demux_1x4; covers the sync path when DEMUX_SYNC_EN is set.
module tb_demux_1x4;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] Entrada;
    logic       validEntrada;
    logic       sync_s;
    logic [7:0] Salida0, Salida1, Salida2, Salida3;
    logic       validSalida0, validSalida1, validSalida2, validSalida3;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_4f = ~clk_4f;

    demux_1x4 #(.WIDTH(8)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
`ifdef DEMUX_SYNC_EN
        .sync         (sync_s),
`endif
        .Salida0      (Salida0),
        .Salida1      (Salida1),
        .Salida2      (Salida2),
        .Salida3      (Salida3),
        .validSalida0 (validSalida0),
        .validSalida1 (validSalida1),
        .validSalida2 (validSalida2),
        .validSalida3 (validSalida3),
        .frame_cnt    (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [3:0] ev, input logic [7:0] efc);
        check({tag, ".s0"}, 32'(Salida0), 32'(e0));
        check({tag, ".s1"}, 32'(Salida1), 32'(e1));
        check({tag, ".s2"}, 32'(Salida2), 32'(e2));
        check({tag, ".s3"}, 32'(Salida3), 32'(e3));
        check({tag, ".v"}, 32'({validSalida3, validSalida2, validSalida1, validSalida0}),
              32'(ev));
        check({tag, ".fc"}, 32'(frame_cnt), 32'(efc));
    endtask

    // Drive one slot and advance past the edge; outputs are sampled 1 time unit later.
    task automatic send(input logic [7:0] d, input logic v);
        Entrada      = d;
        validEntrada = v;
        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        reset = 1'b1; Entrada = 8'h00; validEntrada = 1'b0; sync_s = 1'b0;
        @(posedge clk_4f); #1;
        @(posedge clk_4f); #1;
        check_out("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0);
        reset = 1'b0;

        // Basic frame; outputs must not move before the fourth edge.
        send(8'hA0, 1'b1);
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b1);
        check_out("pre_frame", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0);
        send(8'hA3, 1'b1);
        check_out("frame_a", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111, 8'd1);

        // Invalid slot 1: lane 1 keeps A1, counter does not advance.
        send(8'hC0, 1'b1);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b1);
        send(8'hC3, 1'b1);
        check_out("gap_s1", 8'hC0, 8'hA1, 8'hC2, 8'hC3, 4'b1101, 8'd1);

        // 255 more full frames wrap frame_cnt from 1 to 0; hold checked in the first frame.
        for (int f = 0; f < 255; f++) begin
            for (int k = 0; k < 4; k++) begin
                send(8'(f * 4 + k), 1'b1);
                if (f == 0 && k < 3) begin
                    check_out($sformatf("hold%0d", k), 8'hC0, 8'hA1, 8'hC2, 8'hC3,
                              4'b1101, 8'd1);
                end
            end
        end
        check_out("wrap", 8'hF8, 8'hF9, 8'hFA, 8'hFB, 4'b1111, 8'd0);

        // Reset in slot 2 discards the partial frame.
        send(8'h77, 1'b1);
        send(8'h78, 1'b1);
        reset = 1'b1;
        send(8'h79, 1'b1);
        reset = 1'b0;
        check_out("mid_reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0);
        send(8'h11, 1'b1);
        send(8'h12, 1'b1);
        send(8'h13, 1'b1);
        check_out("post_rst_hold", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0);
        send(8'h14, 1'b1);
        check_out("post_rst", 8'h11, 8'h12, 8'h13, 8'h14, 4'b1111, 8'd1);

`ifdef DEMUX_SYNC_EN
        // Sync in counter slot 2 realigns: 0x55 becomes lane 0, update three edges later.
        send(8'h21, 1'b1);
        send(8'h22, 1'b1);
        sync_s = 1'b1;
        send(8'h55, 1'b1);
        sync_s = 1'b0;
        send(8'h56, 1'b1);
        check_out("sync_hold1", 8'h11, 8'h12, 8'h13, 8'h14, 4'b1111, 8'd1);
        send(8'h57, 1'b1);
        check_out("sync_hold2", 8'h11, 8'h12, 8'h13, 8'h14, 4'b1111, 8'd1);
        send(8'h58, 1'b1);
        check_out("sync_frame", 8'h55, 8'h56, 8'h57, 8'h58, 4'b1111, 8'd2);

        // Reset wins over sync.
        reset = 1'b1;
        sync_s = 1'b1;
        send(8'h99, 1'b1);
        reset = 1'b0;
        sync_s = 1'b0;
        check_out("rst_over_sync", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
